ps2_host_tx: RTL
================

# ps2_host_tx

Host-to-device PS/2 transmitter that sends single command bytes to the keyboard, such as 0xED (set LEDs), 0xF4 (enable) or 0xFF (reset). It is the send path paired with the existing PS/2 keyboard receiver and shares the `PS2_CLK`/`PS2_DAT` open-drain lines with it. It performs request-to-send, shifts out data and parity on device-generated clock edges, and checks the device ACK. While `busy` is high, the receiver must ignore line activity.

## Interface
- `CLOCK_FREQUENCY`, default 25000000: system clock in Hz.
- `INHIBIT_CYC`, default `CLOCK_FREQUENCY/10000`: length of the clock-low inhibit (100 µs; 2500 cycles at the default frequency).
- `TIMEOUT_CYC`, default `CLOCK_FREQUENCY/1000*15`: maximum wait for any device clock edge (15 ms).

Ports:
- `Clock` input, 1 bit: single system clock.
- `reset` input, 1 bit: synchronous, active-high.
- `cmd_data` input, 8 bits: byte to send.
- `cmd_valid` input, 1 bit: request; the byte is accepted when `cmd_valid && cmd_ready`.
- `cmd_ready` output, 1 bit: high only in IDLE.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse when a transfer completes and the ACK was received.
- `error` output, 1 bit: one-cycle pulse on timeout or missing ACK.
- `PS2_CLK` inout, 1 bit: open-drain; driven 0 or released to `z`.
- `PS2_DAT` inout, 1 bit: open-drain; driven 0 or released to `z`.

## Operation
- **Line inputs:** both lines pass through a 2-flop synchronizer. `fall` is a 1-cycle pulse on a synchronized 1→0 transition of `PS2_CLK`.
- **Line drive rule:** a line is released whenever the module is not actively pulling it low. 1 is never driven.
- **Parity:** odd; `par = ~^cmd_data`, latched together with `cmd_data` at acceptance.

States and transitions:
- **IDLE:** both lines released. On acceptance, latch the byte and parity, load the counter with `INHIBIT_CYC-1`, and go to INHIBIT.
- **INHIBIT:** pull `PS2_CLK` low and count down. When the count reaches 0, go to RTS.
- **RTS:** keep `PS2_CLK` low and pull `PS2_DAT` low for one cycle. Then release `PS2_CLK`, clear `bitcnt`, and go to SEND. `PS2_DAT` stays low; this is the start bit.
- **SEND:** on each `fall`, increment `bitcnt`.
  - Edges 1–8 present data bits 0–7, LSB first. A 0 bit pulls `PS2_DAT` low; a 1 bit releases it.
  - Edge 9 presents parity.
  - Edge 10 releases `PS2_DAT` (stop bit) and moves to ACK.
- **ACK:** on the next `fall`, sample synchronized `PS2_DAT`.
  - Low: go to WAIT_IDLE.
  - High: pulse `error` and go to IDLE.
- **WAIT_IDLE:** when synchronized `PS2_CLK` and `PS2_DAT` are both 1, pulse `done` and go to IDLE.

Timeout and reset:
- A single `TIMEOUT_CYC` watchdog runs in SEND, ACK and WAIT_IDLE. It reloads on every `fall` and on entry to SEND.
- If the watchdog expires, pulse `error`, release both lines, and go to IDLE. `error` and `done` are never asserted together.
- `reset` at any point: IDLE, both lines released, and `bitcnt`, counters, `done` and `error` all cleared. This holds mid-transfer too; no pulse is emitted for an aborted transfer.
- `cmd_valid` while busy is ignored and not queued. `cmd_data` is sampled only at acceptance.

## Timing
- Output values after reset: `cmd_ready`=1, `busy`=0, `done`=0, `error`=0, lines `z`.
- From acceptance, `PS2_CLK` is pulled low on the next cycle and held low for `INHIBIT_CYC`+1 cycles.
- `PS2_DAT` goes low one cycle before `PS2_CLK` is released.
- Data updates lag the physical falling edge by 3 cycles: 2 synchronizer cycles plus the register. That is far below the roughly 30 µs clock-low half-period.
- `done` fires 3 cycles after both lines are seen high; `cmd_ready` is high on the following cycle.
- A back-to-back `cmd_valid` is accepted on the first cycle back in IDLE.

## Structure
- **Shared package `ps2_pkg`:** state encoding localparams (IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE), command constants (0xED, 0xF4, 0xFF), and the ACK byte 0xFA for the receiver.
- **Sub-module `ps2_line_sync`:** 2-flop synchronizer for both lines plus the `fall` pulse generator. The receiver reuses it.

## Test plan
- **Send 0xED:** reset, then accept 0xED with a device model clocking at 12 kHz and acknowledging → `PS2_CLK` low for 2501 cycles; the model captures bits 1,0,1,1,0,1,1,1 (LSB first), parity 1 and stop 1; `done` pulses once; `error` stays 0.
- **Send 0x02:** the model checks that parity is 0 → the model reports no framing error and `done` pulses.
- **No ACK:** the model leaves `PS2_DAT` high on edge 11 → `error` pulses one cycle, there is no `done`, and `cmd_ready` returns to 1.
- **Device stops clocking:** the device stops after edge 4 → `error` pulses exactly `TIMEOUT_CYC` cycles after the last `fall`, and both lines read `z`.
- **Reset mid-transfer:** assert `reset` during SEND at edge 6 → next cycle `busy`=0 and lines are `z`; no `done` or `error`; a following 0xFF transfer completes normally with parity 1.
- **`cmd_valid` while busy:** hold `cmd_valid` high with 0x55 during a 0xF4 transfer → only 0xF4 is sent; 0x55 is accepted on the first IDLE cycle after `done`.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, keyboard command bytes
// and the device ACK byte used by the receiver.
package ps2_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_INHIBIT   = 3'd1,
      ST_RTS       = 3'd2,
      ST_SEND      = 3'd3,
      ST_ACK       = 3'd4,
      ST_WAIT_IDLE = 3'd5
   } ps2_state_e;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] DEV_ACK      = 8'hFA;

   // PS/2 frames carry odd parity over the data byte.
   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock and data lines plus a one-cycle
// pulse on a synchronized clock falling edge; shared by transmitter and receiver.
module ps2_line_sync (
   input  logic clk_i,
   input  logic rst_i,
   input  logic ps2_clk_i,
   input  logic ps2_dat_i,
   output logic clk_o,
   output logic dat_o,
   output logic fall_o
);
   logic [2:0] clk_q;
   logic [1:0] dat_q;

   // Reset to the idle (high) level so leaving reset never looks like an edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         clk_q <= '1;
         dat_q <= '1;
      end else begin
         clk_q <= {clk_q[1:0], ps2_clk_i};
         dat_q <= {dat_q[0], ps2_dat_i};
      end
   end

   assign clk_o  = clk_q[1];
   assign dat_o  = dat_q[1];
   assign fall_o = clk_q[2] & ~clk_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: clock inhibit, request-to-send,
// data/parity shifted on device clock edges, ACK check and line-idle wait.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int CLOCK_FREQUENCY = 25000000,
   parameter int INHIBIT_CYC     = CLOCK_FREQUENCY / 10000,
   parameter int TIMEOUT_CYC     = CLOCK_FREQUENCY / 1000 * 15
) (
   input  logic       Clock,
   input  logic       reset,
   input  logic [7:0] cmd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   output logic       busy,
   output logic       done,
   output logic       error,
   inout  wire        PS2_CLK,
   inout  wire        PS2_DAT
);
   localparam int CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LOAD = CNT_W'(INHIBIT_CYC - 1);
   localparam logic [CNT_W-1:0] TO_LOAD  = CNT_W'(TIMEOUT_CYC - 1);

   ps2_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bitcnt_q, bitcnt_d;
   logic [8:0]       tx_q, tx_d;
   logic             done_q, done_d, error_q, error_d;
   logic             clk_s, dat_s, fall;
   logic             clk_low, dat_low;

   ps2_line_sync u_sync (
      .clk_i    (Clock),
      .rst_i    (reset),
      .ps2_clk_i(PS2_CLK),
      .ps2_dat_i(PS2_DAT),
      .clk_o    (clk_s),
      .dat_o    (dat_s),
      .fall_o   (fall)
   );

   always_ff @(posedge Clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         bitcnt_q <= '0;
         tx_q     <= '1;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         bitcnt_q <= bitcnt_d;
         tx_q     <= tx_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitcnt_d = bitcnt_q;
      tx_d     = tx_q;
      done_d   = 1'b0;
      error_d  = 1'b0;

      // One watchdog covers every device-clocked phase; state actions below override it.
      if (state_q inside {ST_SEND, ST_ACK, ST_WAIT_IDLE}) begin
         if (fall) begin
            cnt_d = TO_LOAD;
         end else if (cnt_q == '0) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
         end else begin
            cnt_d = cnt_q - CNT_W'(1);
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               tx_d    = {odd_parity(cmd_data), cmd_data};
               cnt_d   = INH_LOAD;
               state_d = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt_q == '0) state_d = ST_RTS;
            else             cnt_d   = cnt_q - CNT_W'(1);
         end
         ST_RTS: begin
            bitcnt_d = '0;
            cnt_d    = TO_LOAD;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            // tx_q[0] is the bit on the line; the first edge leaves it in place.
            if (fall) begin
               bitcnt_d = bitcnt_q + 4'd1;
               if (bitcnt_q != 4'd0) tx_d = {1'b1, tx_q[8:1]};
               if (bitcnt_q == 4'd9) state_d = ST_ACK;
            end
         end
         ST_ACK: begin
            if (fall) begin
               error_d = dat_s;
               state_d = dat_s ? ST_IDLE : ST_WAIT_IDLE;
            end
         end
         ST_WAIT_IDLE: begin
            // done is shown for one cycle before returning to IDLE.
            if (done_q) begin
               error_d = 1'b0;
               state_d = ST_IDLE;
            end else if (clk_s && dat_s) begin
               done_d  = 1'b1;
               error_d = 1'b0;
               state_d = ST_WAIT_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      clk_low = state_q inside {ST_INHIBIT, ST_RTS};
      dat_low = 1'b0;
      if (state_q == ST_RTS)  dat_low = 1'b1;
      if (state_q == ST_SEND) dat_low = (bitcnt_q == 4'd0) ? 1'b1 : ~tx_q[0];
   end

   assign PS2_CLK   = clk_low ? 1'b0 : 1'bz;
   assign PS2_DAT   = dat_low ? 1'b0 : 1'bz;
   assign cmd_ready = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign error     = error_q;

endmodule
